fog_rate_snapshot: RTL

Decimating accumulator downstream of the FOG closed-loop core. It sums the feedback step and error words over a programmable number of step-sync strobes and freezes each completed window into a snapshot register set. The CPU reads the snapshot through a valid/ack handshake, so rate data crosses to software once per window instead of once per modulation cycle.

---
 rtl/fog_rate_snapshot.sv | 117 +++++++++++
 1 files changed

// File: rtl/fog_rate_snapshot.sv
// ---------------------------------------------------------------------------
// fog_rate_snapshot: windowed step/error accumulator with CPU snapshot handoff
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fog_rate_snapshot #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int SEQ_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_trig,
  input  logic [DATA_W-1:0]       i_step,
  input  logic [DATA_W-1:0]       i_err,
  input  logic [15:0]             i_dec_cnt,
  input  logic                    i_clear,
  input  logic                    i_rd_ack,
  output logic signed [ACC_W-1:0] o_step_acc,
  output logic signed [ACC_W-1:0] o_err_acc,
  output logic [15:0]             o_cnt,
  output logic [SEQ_W-1:0]        o_seq,
  output logic                    o_valid,
  output logic                    o_overrun
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_step_acc;
  logic signed [ACC_W-1:0] r_err_acc;
  logic [15:0]             r_n;
  logic [15:0]             r_win_len;

  logic signed [ACC_W-1:0] w_step_ext;
  logic signed [ACC_W-1:0] w_err_ext;
  logic signed [ACC_W-1:0] w_step_sum;
  logic signed [ACC_W-1:0] w_err_sum;
  logic [15:0]             w_win_new;
  logic [15:0]             w_snap_len;
  logic                    w_idle;
  logic                    w_complete;

  assign w_step_ext = {{(ACC_W-DATA_W){i_step[DATA_W-1]}}, i_step};
  assign w_err_ext  = {{(ACC_W-DATA_W){i_err[DATA_W-1]}}, i_err};
  assign w_idle     = (r_state == S_IDLE);
  assign w_win_new  = (i_dec_cnt == 16'd0) ? 16'd1 : i_dec_cnt;

  // The first sample of a window loads rather than adds.
  assign w_step_sum = w_idle ? w_step_ext : r_step_acc + w_step_ext;
  assign w_err_sum  = w_idle ? w_err_ext  : r_err_acc  + w_err_ext;
  assign w_snap_len = w_idle ? w_win_new  : r_win_len;
  assign w_complete = i_trig && !i_clear &&
                      (w_idle ? (w_win_new == 16'd1) : ((r_n + 16'd1) == r_win_len));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_step_acc <= '0;
      r_err_acc  <= '0;
      r_n        <= '0;
      r_win_len  <= '0;
      o_step_acc <= '0;
      o_err_acc  <= '0;
      o_cnt      <= '0;
      o_seq      <= '0;
      o_valid    <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      if (i_clear) begin
        r_state    <= S_IDLE;
        r_step_acc <= '0;
        r_err_acc  <= '0;
        r_n        <= '0;
      end else if (i_trig) begin
        if (w_idle) begin
          r_win_len <= w_win_new;
        end
        if (w_complete) begin
          r_state    <= S_IDLE;
          r_step_acc <= '0;
          r_err_acc  <= '0;
          r_n        <= '0;
        end else begin
          r_state    <= S_ACCUM;
          r_step_acc <= w_step_sum;
          r_err_acc  <= w_err_sum;
          r_n        <= r_n + 16'd1;
        end
      end

      if (i_rd_ack && o_valid) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end

      // Completion overrides a coincident ack: the fresh snapshot stays valid.
      if (w_complete) begin
        o_step_acc <= w_step_sum;
        o_err_acc  <= w_err_sum;
        o_cnt      <= w_snap_len;
        o_seq      <= o_seq + {{(SEQ_W-1){1'b0}}, 1'b1};
        o_valid    <= 1'b1;
        if (o_valid && !i_rd_ack) begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
